// File: rtl/rev_mac_pkg.sv
// ============================================================================
// Module : rev_mac_pkg
// Brief  : Shared states, default sizes and HNG ancilla for the reversible MAC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rev_mac_pkg;

    localparam int   c_DEF_WIDTH   = 4;
    localparam int   c_DEF_ACC_W   = 12;
    // D input of an HNG gate tied low turns its S output into a majority carry
    localparam logic c_HNG_ANCILLA = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rev_full_adder.sv
// ============================================================================
// Module : hng_gate / rev_full_adder
// Brief  : HNG reversible gate and the one-bit full adder built from it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hng_gate (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_p,
    output logic o_q,
    output logic o_r,
    output logic o_s
);
    assign o_p = i_a;
    assign o_q = i_b;
    assign o_r = i_a ^ i_b ^ i_c;
    assign o_s = ((i_a ^ i_b) & i_c) ^ (i_a & i_b) ^ i_d;
endmodule

module rev_full_adder
    import rev_mac_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    logic w_unused_p;
    logic w_unused_q;

    hng_gate u_hng (
        .i_a (i_a),
        .i_b (i_b),
        .i_c (i_cin),
        .i_d (c_HNG_ANCILLA),
        .o_p (w_unused_p),
        .o_q (w_unused_q),
        .o_r (o_sum),
        .o_s (o_cout)
    );
endmodule

`default_nettype wire

// File: rtl/rev_seq_mac.sv
// ============================================================================
// Module : rev_seq_mac
// Brief  : Shift-and-add MAC; one (a,b) term per WIDTH+2 cycles, result on last.
//          Define REV_SEQ_MAC_SATURATE_EN to clamp the accumulator on overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rev_seq_mac
    import rev_mac_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int ACC_W = c_DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_clr,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_clr;
    logic               r_last;
    logic [2*WIDTH-1:0] r_prod;
    logic [ACC_W-1:0]   r_acc;

    logic [ACC_W-1:0]   w_op_x;
    logic [ACC_W-1:0]   w_op_y;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W:0]     w_c;
    logic               w_accept;
    logic               w_cnt_last;

    assign w_accept   = in_valid & in_ready;
    assign w_cnt_last = (r_cnt == CNT_W'(WIDTH - 1));

    // One adder serves both stages: partial products in MUL, the term in ACC
    always_comb begin
        w_op_x = ACC_W'(r_prod);
        w_op_y = ACC_W'(r_a) << r_cnt;
        if (r_state == ACC) begin
            w_op_x = r_clr ? '0 : r_acc;
            w_op_y = ACC_W'(r_prod);
        end
    end

    assign w_c[0] = 1'b0;

    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_ripple
        rev_full_adder u_fa (
            .i_a    (w_op_x[gi]),
            .i_b    (w_op_y[gi]),
            .i_cin  (w_c[gi]),
            .o_sum  (w_sum[gi]),
            .o_cout (w_c[gi+1])
        );
    end

`ifdef REV_SEQ_MAC_SATURATE_EN
    assign w_acc_next = w_c[ACC_W] ? {ACC_W{1'b1}} : w_sum;
`else
    logic w_unused_cout;
    assign w_unused_cout = w_c[ACC_W];
    assign w_acc_next    = w_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = MUL;
            MUL:     if (w_cnt_last) w_next = ACC;
            ACC:     w_next = r_last ? DONE : IDLE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_clr  <= 1'b0;
            r_last <= 1'b0;
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a    <= in_a;
                        r_b    <= in_b;
                        r_clr  <= in_clr;
                        r_last <= in_last;
                        r_prod <= '0;
                        r_cnt  <= '0;
                    end
                end
                MUL: begin
                    if (r_b[r_cnt]) begin
                        r_prod <= w_sum[2*WIDTH-1:0];
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                ACC: begin
                    r_acc <= w_acc_next;
                end
                DONE: begin
                    if (out_ready) begin
                        r_acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) & ~rst;
    assign out_valid = (r_state == DONE);
    assign out_data  = out_valid ? r_acc : '0;

endmodule

`default_nettype wire

// File: tb/tb_rev_seq_mac.sv
// ============================================================================
// Module : tb_rev_seq_mac
// Brief  : Self-checking bench for rev_seq_mac with an arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rev_seq_mac;
    localparam int WIDTH = 4;
    localparam int ACC_W = 12;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_clr;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;

    int checks    = 0;
    int failures  = 0;
    int model_acc = 0;
    int last_out  = 0;

    rev_seq_mac #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_clr    (in_clr),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_add(input int acc, input int a, input int b, input bit clr);
        int s;
        s = (clr ? 0 : acc) + a * b;
`ifdef REV_SEQ_MAC_SATURATE_EN
        if (s > MAXV) s = MAXV;
`else
        s = s % (MAXV + 1);
`endif
        return s;
    endfunction

    // Offers one term at a negedge, then sits on the bus with junk while busy.
    task automatic send(input int a, input int b, input bit clr, input bit last);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
        in_clr   = clr;
        in_last  = last;
        @(negedge clk);
        model_acc = model_add(model_acc, a, b, clr);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4);
            in_a     = WIDTH'($urandom_range(15, 0));
            in_b     = WIDTH'($urandom_range(15, 0));
            in_clr   = 1'($urandom_range(1, 0));
            in_last  = 1'($urandom_range(1, 0));
            check("busy_ready", int'(in_ready), 0);
            check("busy_valid", int'(out_valid), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (last) begin
            check("result_valid", int'(out_valid), 1);
            check("result_data", int'(out_data), model_acc);
            last_out = int'(out_data);
        end else begin
            check("idle_again", int'(in_ready), 1);
        end
    endtask

    task automatic take(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), last_out);
            check("hold_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drop_valid", int'(out_valid), 0);
        check("drop_data", int'(out_data), 0);
        model_acc = 0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_clr    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_ready", int'(in_ready), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send(15, 15, 1, 1);
        check("single_225", last_out, 225);
        take(0);

        send(1, 5, 1, 0);
        send(2, 6, 0, 0);
        send(3, 7, 0, 0);
        send(4, 8, 0, 1);
        check("dot_70", last_out, 70);
        take(5);

        send(2, 3, 1, 1);
        check("after_clear_6", last_out, 6);
        take(1);

        for (int i = 0; i < 19; i++) send(15, 15, i == 0, i == 18);
`ifdef REV_SEQ_MAC_SATURATE_EN
        check("overflow_sat", last_out, 4095);
`else
        check("overflow_wrap", last_out, 179);
`endif
        take(0);

        send(9, 9, 1, 0);
        send(0, 9, 1, 0);
        send(3, 4, 0, 1);
        check("midclr_12", last_out, 12);
        take(0);
        send(9, 9, 1, 0);
        send(0, 9, 0, 1);
        check("zero_term_81", last_out, 81);
        take(0);
        send(0, 9, 1, 1);
        check("zero_only", last_out, 0);
        take(0);

        // reset landing in the second MUL cycle
        in_valid = 1'b1;
        in_a     = 4'd11;
        in_b     = 4'd13;
        in_clr   = 1'b1;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_ready", int'(in_ready), 0);
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_data", int'(out_data), 0);
        repeat (2) @(negedge clk);
        check("mrst_hold_ready", int'(in_ready), 0);
        rst       = 1'b0;
        model_acc = 0;
        @(negedge clk);
        send(7, 6, 1, 1);
        check("post_rst_42", last_out, 42);
        take(0);

        for (int t = 0; t < 8; t++) begin
            int len;
            len = $urandom_range(5, 1);
            for (int k = 0; k < len; k++) begin
                send($urandom_range(15, 0), $urandom_range(15, 0),
                     (k == 0) ? 1'b1 : 1'($urandom_range(3, 0) == 0), k == len - 1);
            end
            take($urandom_range(2, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
